instruction_cache: RTL and testbench

//   Direct-mapped, read-only instruction cache between the IF-stage PC and a slow

---
 rtl/instruction_cache.sv | 217 +++++++++++++++++++++
 tb/tb_instruction_cache.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// -----------------------------------------------------------------------------
// instruction_cache
//   Direct-mapped, read-only instruction cache between the IF-stage PC and a
//   slow backing instruction memory. A hit returns the instruction in the same
//   cycle. A miss raises stall at once. The whole line is then refilled, one
//   word per beat, using a memReq/memReady handshake. Beats are fetched in
//   order starting from word 0.
//
// Ports
//   clk          rising-edge clock
//   resetN       asynchronous active-low reset
//   address      PC byte address from IF stage
//   instruction  instruction word at address, meaningful only when stall==0
//   stall        1 while the current address misses or a fill is in progress
//   invalidate   1-cycle pulse: clear all valid bits, abort any fill
//   memReq       backing-memory read request (registered)
//   memAddress   word-aligned byte address of the requested word (registered)
//   memReady     memData valid this cycle, beat accepted
//   memData      returned instruction word
//   hitCount     hits counted since reset, wraps
//   missCount    misses counted since reset, wraps
// -----------------------------------------------------------------------------
module instruction_cache #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [31:0]           instruction,
    output logic                  stall,
    input  logic                  invalidate,
    output logic                  memReq,
    output logic [ADDR_WIDTH-1:0] memAddress,
    input  logic                  memReady,
    input  logic [31:0]           memData,
    output logic [31:0]           hitCount,
    output logic [31:0]           missCount
);

    localparam int WORD_BITS  = $clog2(WORDS_PER_LINE);
    localparam int INDEX_BITS = $clog2(LINES);
    localparam int TAG_BITS   = ADDR_WIDTH - 2 - WORD_BITS - INDEX_BITS;
    localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(WORDS_PER_LINE - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } cacheState_t;

    cacheState_t state;
    cacheState_t stateNext;

    // Storage: the valid bits are reset. The tag and data contents are never
    // read until a line's valid bit is set.
    logic [LINES-1:0]    validBits;
    logic [TAG_BITS-1:0] tagArray  [LINES];
    logic [31:0]         dataArray [LINES][WORDS_PER_LINE];

    // Request address fields.
    logic [WORD_BITS-1:0]  reqWord;
    logic [INDEX_BITS-1:0] reqIndex;
    logic [TAG_BITS-1:0]   reqTag;
    logic [1:0]            unusedByteOffset;

    // Fill bookkeeping, latched when the miss is taken.
    logic [TAG_BITS-1:0]   fillTag;
    logic [INDEX_BITS-1:0] fillIndex;
    logic [WORD_BITS-1:0]  beat;
    logic [WORD_BITS-1:0]  beatNext;
    logic                  lastBeat;
    logic                  fillWrite;
    logic                  hit;

    assign reqWord          = address[2 +: WORD_BITS];
    assign reqIndex         = address[2 + WORD_BITS +: INDEX_BITS];
    assign reqTag           = address[ADDR_WIDTH-1 -: TAG_BITS];
    assign unusedByteOffset = address[1:0];

    assign beatNext = beat + WORD_BITS'(1);
    assign lastBeat = (beat == LAST_BEAT);
    // A beat arriving together with invalidate is dropped along with the fill.
    assign fillWrite = (state == FILL) && memReady && !invalidate;

    // Hit detection against the line selected by the current PC.
    always_comb begin
        hit = 1'b0;
        if (validBits[reqIndex] && (tagArray[reqIndex] == reqTag)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

    // Zero-latency read path and stall generation.
    always_comb begin
        instruction = 32'h0000_0000;
        stall       = 1'b1;
        if (state == FILL) begin
            stall = 1'b1;
        end else if (hit) begin
            instruction = dataArray[reqIndex][reqWord];
            stall       = 1'b0;
        end else begin
            stall = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next-state logic: invalidate wins over a final beat in the same cycle.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (!hit) begin
                    stateNext = FILL;
                end else begin
                    stateNext = IDLE;
                end
            end
            FILL: begin
                if (invalidate) begin
                    stateNext = IDLE;
                end else if (memReady && lastBeat) begin
                    stateNext = IDLE;
                end else begin
                    stateNext = FILL;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Fill sequencing: latch the missing line and drive the registered memory request.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fillTag    <= {TAG_BITS{1'b0}};
            fillIndex  <= {INDEX_BITS{1'b0}};
            beat       <= {WORD_BITS{1'b0}};
            memReq     <= 1'b0;
            memAddress <= {ADDR_WIDTH{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        fillTag    <= reqTag;
                        fillIndex  <= reqIndex;
                        beat       <= {WORD_BITS{1'b0}};
                        memReq     <= 1'b1;
                        memAddress <= {reqTag, reqIndex, {WORD_BITS{1'b0}}, 2'b00};
                    end
                end
                FILL: begin
                    if (invalidate) begin
                        beat   <= {WORD_BITS{1'b0}};
                        memReq <= 1'b0;
                    end else if (memReady && lastBeat) begin
                        beat   <= {WORD_BITS{1'b0}};
                        memReq <= 1'b0;
                    end else if (memReady) begin
                        beat       <= beatNext;
                        memAddress <= {fillTag, fillIndex, beatNext, 2'b00};
                    end
                end
                default: begin
                    beat   <= {WORD_BITS{1'b0}};
                    memReq <= 1'b0;
                end
            endcase
        end
    end

    // Valid bits: cleared by reset or invalidate, set when a fill completes.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            validBits <= {LINES{1'b0}};
        end else if (invalidate) begin
            validBits <= {LINES{1'b0}};
        end else if (fillWrite && lastBeat) begin
            validBits[fillIndex] <= 1'b1;
        end
    end

    // Tag/data write port. The tag is written with the last beat of the line.
    always_ff @(posedge clk) begin
        if (fillWrite) begin
            dataArray[fillIndex][beat] <= memData;
            if (lastBeat) begin
                tagArray[fillIndex] <= fillTag;
            end
        end
    end

    // Hit/miss statistics. Only lookups made in IDLE are counted.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hitCount  <= 32'd0;
            missCount <= 32'd0;
        end else if (state == IDLE) begin
            if (hit) begin
                hitCount <= hitCount + 32'd1;
            end else begin
                missCount <= missCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// -----------------------------------------------------------------------------
// tb_instruction_cache
//   Self-checking bench for instruction_cache. The driver pushes one expected
//   response into a queue for every cycle. The expected response comes from a
//   line-level model that tracks which line bases are resident. The model also
//   tracks how many beats of the current fill have been delivered. A separate
//   monitor pops the queue and compares the DUT's outputs. Directed sequences
//   are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_instruction_cache;

    logic        clk;
    logic        resetN;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        stall;
    logic        invalidate;
    logic        memReq;
    logic [31:0] memAddress;
    logic        memReady;
    logic [31:0] memData;
    logic [31:0] hitCount;
    logic [31:0] missCount;

    int checks = 0;
    int errors = 0;
    bit useSimple = 1'b1;

    typedef struct {
        bit          stall;
        logic [31:0] instr;
        bit          memReq;
        logic [31:0] memAddr;
        logic [31:0] hits;
        logic [31:0] misses;
    } exp_t;

    exp_t sbq[$];

    // Line-level reference model.
    bit          mValid [16];
    logic [31:0] mLine  [16];
    bit          fillActive;
    logic [31:0] fillBase;
    int          beatsDone;
    logic [31:0] mHits;
    logic [31:0] mMisses;

    // DUT values sampled by the driver, used by the directed sequences.
    logic        sStall;
    logic        sMemReq;
    logic [31:0] sMemAddr;
    logic [31:0] sInstr;

    instruction_cache dut (
        .clk         (clk),
        .resetN      (resetN),
        .address     (address),
        .instruction (instruction),
        .stall       (stall),
        .invalidate  (invalidate),
        .memReq      (memReq),
        .memAddress  (memAddress),
        .memReady    (memReady),
        .memData     (memData),
        .hitCount    (hitCount),
        .missCount   (missCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a, input bit simple);
        if (simple) begin
            return 32'h0000_1000 + {30'd0, a[3:2]};
        end
        return ((a ^ 32'hDEAD_BEEF) * 32'h0001_0193) + 32'h1357_9BDF;
    endfunction

    // Backing memory: it always returns the word at the requested address.
    assign memData = memWord(memAddress, useSimple);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
        fillActive = 1'b0;
        fillBase   = 32'd0;
        beatsDone  = 0;
        mHits      = 32'd0;
        mMisses    = 32'd0;
    endtask

    // Monitor: pop one expectation per driven cycle and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("stall", {31'd0, stall}, {31'd0, e.stall});
                if (!e.stall) chk("instruction", instruction, e.instr);
                chk("memReq", {31'd0, memReq}, {31'd0, e.memReq});
                if (e.memReq) chk("memAddress", memAddress, e.memAddr);
                chk("hitCount", hitCount, e.hits);
                chk("missCount", missCount, e.misses);
            end
        end
    end

    // One clock cycle: drive the inputs, predict the outputs, then advance the model at the edge.
    task automatic cycle(input logic [31:0] a, input logic inv, input logic rdy);
        exp_t e;
        bit   mhit;
        int   ix;
        int   fx;
        @(negedge clk);
        #1;
        address    = a;
        invalidate = inv;
        memReady   = rdy;
        ix   = int'((a >> 4) & 32'h0000_000F);
        mhit = !fillActive && mValid[ix] && (mLine[ix] == (a & ~32'h0000_000F));
        e.stall   = fillActive || !mhit;
        e.instr   = memWord({a[31:2], 2'b00}, useSimple);
        e.memReq  = fillActive;
        e.memAddr = fillBase + 32'(4 * beatsDone);
        e.hits    = mHits;
        e.misses  = mMisses;
        sbq.push_back(e);
        #1;
        sStall   = stall;
        sMemReq  = memReq;
        sMemAddr = memAddress;
        sInstr   = instruction;
        @(posedge clk);
        if (!fillActive) begin
            if (mhit) begin
                mHits = mHits + 32'd1;
            end else begin
                mMisses    = mMisses + 32'd1;
                fillActive = 1'b1;
                fillBase   = a & ~32'h0000_000F;
                beatsDone  = 0;
            end
            if (inv) for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
        end else if (inv) begin
            for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
            fillActive = 1'b0;
        end else if (rdy) begin
            beatsDone++;
            if (beatsDone == 4) begin
                fx = int'((fillBase >> 4) & 32'h0000_000F);
                mValid[fx] = 1'b1;
                mLine[fx]  = fillBase;
                fillActive = 1'b0;
            end
        end
    endtask

    // Access address a with memReady held high; n returns the number of stalled cycles.
    task automatic fillAt(input logic [31:0] a, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(a, 1'b0, 1'b1);
            if (!sStall) break;
            n++;
        end
    endtask

    task automatic doReset();
        resetN     = 1'b0;
        address    = 32'd0;
        invalidate = 1'b0;
        memReady   = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_memReq", {31'd0, memReq}, 32'd0);
        chk("reset_memAddress", memAddress, 32'd0);
        chk("reset_hitCount", hitCount, 32'd0);
        chk("reset_missCount", missCount, 32'd0);
        #1;
        resetN = 1'b1;
        modelReset();
    endtask

    initial begin
        int n;
        logic [31:0] seenAddr [4];
        logic [31:0] cur;
        logic [31:0] tmp;
        resetN     = 1'b0;
        address    = 32'd0;
        invalidate = 1'b0;
        memReady   = 1'b0;
        modelReset();

        // Cold miss, then a hit sweep, using simple data values 0x1000+word.
        useSimple = 1'b1;
        doReset();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(32'h0000_0040, 1'b0, 1'b1);
            if (sMemReq && n >= 1 && n <= 4) seenAddr[n-1] = sMemAddr;
            if (!sStall) break;
            n++;
        end
        chk("cold_stall_cycles", 32'(n), 32'd5);
        chk("cold_addr0", seenAddr[0], 32'h0000_0040);
        chk("cold_addr1", seenAddr[1], 32'h0000_0044);
        chk("cold_addr2", seenAddr[2], 32'h0000_0048);
        chk("cold_addr3", seenAddr[3], 32'h0000_004C);
        for (int w = 0; w < 4; w++) begin
            cycle(32'h0000_0040 + 32'(4 * w), 1'b0, 1'b0);
            chk("sweep_stall", {31'd0, sStall}, 32'd0);
            if (w == 2) chk("sweep_instr_0x48", sInstr, 32'h0000_1002);
        end
        #1;
        chk("sweep_hitCount", hitCount, 32'd5);
        chk("sweep_missCount", missCount, 32'd1);

        // Slow memory: memReady is high on every third fill cycle.
        useSimple = 1'b0;
        doReset();
        n = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(32'h0000_0080, 1'b0, (i > 0) && ((i - 1) % 3 == 2));
            if (!sStall) break;
            n++;
        end
        chk("slow_stall_cycles", 32'(n), 32'd13);

        // Conflict eviction: 0x140 uses the same index as 0x40 but a different tag.
        doReset();
        fillAt(32'h0000_0040, n);
        chk("conflict_fill1", 32'(n), 32'd5);
        fillAt(32'h0000_0140, n);
        chk("conflict_fill2", 32'(n), 32'd5);
        fillAt(32'h0000_0040, n);
        chk("conflict_fill3", 32'(n), 32'd5);
        #1;
        chk("conflict_missCount", missCount, 32'd3);

        // Invalidate at beat 2 of a fill.
        doReset();
        fillAt(32'h0000_0040, n);
        cycle(32'h0000_00C0, 1'b0, 1'b1);
        cycle(32'h0000_00C0, 1'b0, 1'b1);
        cycle(32'h0000_00C0, 1'b0, 1'b1);
        cycle(32'h0000_00C0, 1'b1, 1'b1);
        chk("inv_beat2_addr", sMemAddr, 32'h0000_00C8);
        cycle(32'h0000_00C0, 1'b0, 1'b1);
        chk("inv_memReq_drop", {31'd0, sMemReq}, 32'd0);
        chk("inv_remiss_stall", {31'd0, sStall}, 32'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(32'h0000_00C0, 1'b0, 1'b1);
            if (!sStall) break;
            n++;
        end
        chk("inv_refill_beats", 32'(n), 32'd4);
        fillAt(32'h0000_0040, n);
        chk("inv_old_line_misses", 32'(n), 32'd5);

        // Asynchronous reset asserted between clock edges during a fill.
        doReset();
        fillAt(32'h0000_0040, n);
        cycle(32'h0000_0080, 1'b0, 1'b1);
        cycle(32'h0000_0080, 1'b0, 1'b1);
        #2;
        resetN = 1'b0;
        #1;
        chk("areset_memReq", {31'd0, memReq}, 32'd0);
        chk("areset_hitCount", hitCount, 32'd0);
        chk("areset_missCount", missCount, 32'd0);
        chk("areset_stall", {31'd0, stall}, 32'd1);
        #1;
        resetN = 1'b1;
        modelReset();
        fillAt(32'h0000_0040, n);
        chk("areset_line_misses", 32'(n), 32'd5);

        // Randomized run over a few tags per index so that conflicts occur.
        cur = 32'h0000_0040;
        for (int i = 0; i < 3000; i++) begin
            tmp = 32'($urandom_range(0, 9));
            if (tmp < 32'd4) begin
                cur = {22'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                       2'($urandom_range(0, 3)), 2'b00};
            end else if (tmp < 32'd7) begin
                cur = (cur & ~32'h0000_000F) | ((cur + 32'd4) & 32'h0000_000C);
            end
            cycle(cur, $urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0);
        end

        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
